// File: rtl/cond_issue_sched.sv
// Issue-stage condition scheduler: owns CPSR, counts in-flight flag writers,
// and decides execute / annul / stall for each decoded instruction.
module cond_issue_sched #(
  parameter int MAXPEND = 3,
  parameter int CNTW    = 2
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            instvalidin,
  output logic            instreadyout,
  input  logic [3:0]      condin,
  input  logic            setflagsin,
  input  logic            flagwrvalidin,
  input  logic [3:0]      flagsin,
  input  logic            flushin,
  output logic            issuevalidout,
  output logic            issueexecout,
  output logic [3:0]      cpsrout,
  output logic [CNTW-1:0] pendout,
  output logic            errout
);

  logic [3:0]      cpsr_q, cpsr_d;
  logic [CNTW-1:0] pend_q, pend_d;
  logic            issue_valid_q, issue_valid_d;
  logic            issue_exec_q, issue_exec_d;
  logic            err_q, err_d;

  logic [3:0] eff;
  logic [2:0] cond;
  logic       sel, z, c, n, v;
  logic       cond_raw, cond_true;
  logic       pend_zero, dep_stall, cap_stall;
  logic       accepted, inc, dec;

  assign cond = condin[3:1];
  assign sel  = condin[0];
  assign eff  = flagwrvalidin ? flagsin : cpsr_q;
  assign z    = eff[0];
  assign c    = eff[1];
  assign n    = eff[2];
  assign v    = eff[3];

  always_comb begin
    cond_raw = 1'b0;
    unique case (cond)
      3'b000: cond_raw = z;
      3'b001: cond_raw = c;
      3'b010: cond_raw = n;
      3'b011: cond_raw = v;
      3'b100: cond_raw = c & ~z;
      3'b101: cond_raw = ~(n ^ v);
      3'b110: cond_raw = ~z & ~(n ^ v);
      default: cond_raw = 1'b0;
    endcase
  end

  assign cond_true = (cond == 3'b111) ? 1'b1 : (sel ^ cond_raw);

  // A sole pending writer retiring now lets the bypassed flags decide.
  assign pend_zero = (pend_q == '0);
  assign dep_stall = (cond != 3'b111) && !pend_zero &&
                     !((pend_q == CNTW'(1)) && flagwrvalidin);
  assign cap_stall = setflagsin && (pend_q == CNTW'(MAXPEND)) &&
                     !flagwrvalidin;

  assign instreadyout = reset_n & ~flushin & ~dep_stall & ~cap_stall;
  assign accepted     = instvalidin & instreadyout;
  assign inc          = accepted & setflagsin & cond_true;
  assign dec          = flagwrvalidin & ~pend_zero;

  always_comb begin
    cpsr_d        = flagwrvalidin ? flagsin : cpsr_q;
    issue_valid_d = accepted;
    issue_exec_d  = accepted & cond_true;
    err_d         = flagwrvalidin & pend_zero & ~flushin;
    if (flushin)
      pend_d = '0;
    else
      pend_d = pend_q + CNTW'(inc) - CNTW'(dec);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cpsr_q        <= '0;
      pend_q        <= '0;
      issue_valid_q <= 1'b0;
      issue_exec_q  <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      cpsr_q        <= cpsr_d;
      pend_q        <= pend_d;
      issue_valid_q <= issue_valid_d;
      issue_exec_q  <= issue_exec_d;
      err_q         <= err_d;
    end
  end

  assign issuevalidout = issue_valid_q;
  assign issueexecout  = issue_exec_q;
  assign cpsrout       = cpsr_q;
  assign pendout       = pend_q;
  assign errout        = err_q;

endmodule

// File: tb/tb_cond_issue_sched.sv
// Directed vector bench for cond_issue_sched.
// Each record is one cycle: inputs, expected ready, expected registered outputs.
module tb_cond_issue_sched;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       instvalidin;
  logic       instreadyout;
  logic [3:0] condin;
  logic       setflagsin;
  logic       flagwrvalidin;
  logic [3:0] flagsin;
  logic       flushin;
  logic       issuevalidout;
  logic       issueexecout;
  logic [3:0] cpsrout;
  logic [1:0] pendout;
  logic       errout;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  cond_issue_sched #(.MAXPEND(3), .CNTW(2)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .instvalidin  (instvalidin),
    .instreadyout (instreadyout),
    .condin       (condin),
    .setflagsin   (setflagsin),
    .flagwrvalidin(flagwrvalidin),
    .flagsin      (flagsin),
    .flushin      (flushin),
    .issuevalidout(issuevalidout),
    .issueexecout (issueexecout),
    .cpsrout      (cpsrout),
    .pendout      (pendout),
    .errout       (errout)
  );

  typedef struct {
    logic       rst_n;
    logic       v;
    logic [3:0] cnd;
    logic       sf;
    logic       fwv;
    logic [3:0] fl;
    logic       fsh;
    logic       e_rdy;
    logic       e_iv;
    logic       e_ie;
    logic [3:0] e_cpsr;
    logic [1:0] e_pend;
    logic       e_err;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
    logic rst_n, logic v, logic [3:0] cnd, logic sf, logic fwv,
    logic [3:0] fl, logic fsh, logic e_rdy, logic e_iv, logic e_ie,
    logic [3:0] e_cpsr, logic [1:0] e_pend, logic e_err);
    vec_t r;
    r.rst_n = rst_n; r.v = v; r.cnd = cnd; r.sf = sf; r.fwv = fwv;
    r.fl = fl; r.fsh = fsh; r.e_rdy = e_rdy; r.e_iv = e_iv;
    r.e_ie = e_ie; r.e_cpsr = e_cpsr; r.e_pend = e_pend; r.e_err = e_err;
    return r;
  endfunction

  task automatic chk(input string nm, input int idx, input int act,
                     input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s step %0d: got %0d want %0d", nm, idx, act, exp);
    end
  endtask

  task automatic run_vec(input int idx, input vec_t t);
    reset_n       = t.rst_n;
    instvalidin   = t.v;
    condin        = t.cnd;
    setflagsin    = t.sf;
    flagwrvalidin = t.fwv;
    flagsin       = t.fl;
    flushin       = t.fsh;
    #1;
    chk("ready", idx, int'(instreadyout), int'(t.e_rdy));
    @(posedge clk);
    #1;
    chk("issuevalid", idx, int'(issuevalidout), int'(t.e_iv));
    if (t.e_iv)
      chk("issueexec", idx, int'(issueexecout), int'(t.e_ie));
    chk("cpsr", idx, int'(cpsrout), int'(t.e_cpsr));
    chk("pend", idx, int'(pendout), int'(t.e_pend));
    chk("err", idx, int'(errout), int'(t.e_err));
  endtask

  initial begin
    reset_n = 1'b0; instvalidin = 1'b0; condin = 4'b1110;
    setflagsin = 1'b0; flagwrvalidin = 1'b0; flagsin = 4'b0;
    flushin = 1'b0;
    @(posedge clk);
    #1;

    //        rst v  cond     sf fwv flags   fl  rdy iv ie cpsr     pd err
    vecs.push_back(mk(0, 1, 4'b1110, 0, 0, 4'b0000, 0, 0, 0, 0, 4'b0000, 0, 0));
    vecs.push_back(mk(1, 1, 4'b1110, 0, 0, 4'b0000, 0, 1, 1, 1, 4'b0000, 0, 0));
    vecs.push_back(mk(1, 1, 4'b1110, 1, 0, 4'b0000, 0, 1, 1, 1, 4'b0000, 1, 0));
    vecs.push_back(mk(1, 1, 4'b0000, 0, 0, 4'b0000, 0, 0, 0, 0, 4'b0000, 1, 0));
    vecs.push_back(mk(1, 1, 4'b0000, 0, 1, 4'b0001, 0, 1, 1, 1, 4'b0001, 0, 0));
    vecs.push_back(mk(1, 1, 4'b0001, 1, 0, 4'b0000, 0, 1, 1, 0, 4'b0001, 0, 0));
    vecs.push_back(mk(1, 1, 4'b1110, 1, 0, 4'b0000, 0, 1, 1, 1, 4'b0001, 1, 0));
    vecs.push_back(mk(1, 1, 4'b1110, 1, 0, 4'b0000, 0, 1, 1, 1, 4'b0001, 2, 0));
    vecs.push_back(mk(1, 1, 4'b1110, 1, 0, 4'b0000, 0, 1, 1, 1, 4'b0001, 3, 0));
    vecs.push_back(mk(1, 1, 4'b1110, 1, 0, 4'b0000, 0, 0, 0, 0, 4'b0001, 3, 0));
    vecs.push_back(mk(1, 1, 4'b1110, 1, 1, 4'b0001, 0, 1, 1, 1, 4'b0001, 3, 0));
    vecs.push_back(mk(1, 0, 4'b1110, 0, 1, 4'b0001, 0, 1, 0, 0, 4'b0001, 2, 0));
    vecs.push_back(mk(1, 1, 4'b1110, 1, 1, 4'b1010, 1, 0, 0, 0, 4'b1010, 0, 0));
    vecs.push_back(mk(1, 0, 4'b1110, 0, 1, 4'b0100, 0, 1, 0, 0, 4'b0100, 0, 1));
    vecs.push_back(mk(1, 0, 4'b1110, 0, 0, 4'b0000, 0, 1, 0, 0, 4'b0100, 0, 0));
    vecs.push_back(mk(1, 1, 4'b0100, 0, 0, 4'b0000, 0, 1, 1, 1, 4'b0100, 0, 0));
    vecs.push_back(mk(1, 1, 4'b1010, 0, 0, 4'b0000, 0, 1, 1, 0, 4'b0100, 0, 0));
    vecs.push_back(mk(1, 1, 4'b1011, 0, 0, 4'b0000, 0, 1, 1, 1, 4'b0100, 0, 0));
    vecs.push_back(mk(1, 1, 4'b1000, 0, 1, 4'b0010, 0, 1, 1, 1, 4'b0010, 0, 1));
    vecs.push_back(mk(1, 1, 4'b1100, 0, 0, 4'b0000, 0, 1, 1, 1, 4'b0010, 0, 0));
    vecs.push_back(mk(1, 1, 4'b0110, 0, 0, 4'b0000, 0, 1, 1, 0, 4'b0010, 0, 0));
    vecs.push_back(mk(1, 1, 4'b0010, 0, 0, 4'b0000, 0, 1, 1, 1, 4'b0010, 0, 0));
    vecs.push_back(mk(1, 1, 4'b1111, 0, 0, 4'b0000, 0, 1, 1, 1, 4'b0010, 0, 0));
    vecs.push_back(mk(1, 1, 4'b1001, 0, 0, 4'b0000, 0, 1, 1, 0, 4'b0010, 0, 0));

    foreach (vecs[i]) run_vec(i, vecs[i]);

    // Reset with two writers in flight, then a late flag return.
    reset_n = 1'b1; instvalidin = 1'b1; condin = 4'b1110;
    setflagsin = 1'b1; flagwrvalidin = 1'b0; flushin = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("seq_pend_before_reset", 100, int'(pendout), 2);
    reset_n = 1'b0; flagwrvalidin = 1'b1; flagsin = 4'b0101;
    #1;
    chk("seq_ready_in_reset", 101, int'(instreadyout), 0);
    @(posedge clk);
    #1;
    chk("seq_pend_after_reset", 102, int'(pendout), 0);
    chk("seq_cpsr_after_reset", 103, int'(cpsrout), 0);
    chk("seq_iv_after_reset", 104, int'(issuevalidout), 0);
    reset_n = 1'b1; instvalidin = 1'b0; setflagsin = 1'b0;
    flagwrvalidin = 1'b1; flagsin = 4'b1111;
    @(posedge clk);
    #1;
    chk("seq_late_err", 105, int'(errout), 1);
    chk("seq_late_cpsr", 106, int'(cpsrout), 15);
    chk("seq_late_pend", 107, int'(pendout), 0);
    flagwrvalidin = 1'b0;
    @(posedge clk);
    #1;
    chk("seq_err_one_cycle", 108, int'(errout), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cond_issue_sched.md
Name: cond_issue_sched

Overview:
Issue-stage condition scheduler for the ARM-subset pipeline. It owns the architectural CPSR flag register and tracks in-flight flag-setting instructions. For each decoded instruction it decides one of three outcomes: issue-and-execute, issue-annulled (converted to NOP), or stall until the flags it depends on are resolved. It sits between decode and execute. The execute stage returns flag results through the flag write-back port.

Parameters:
MAXPEND, 3, maximum number of in-flight flag-setting instructions; range 1..3.
CNTW, 2, width of the pending counter; must satisfy 2^CNTW > MAXPEND.

Ports:
clk  input  1  rising-edge clock, the only clock
reset_n  input  1  synchronous active-low reset
instvalidin  input  1  decode presents an instruction
instreadyout  output  1  scheduler accepts the instruction this cycle
condin  input  4  instruction condition field
setflagsin  input  1  instruction writes CPSR (S bit)
flagwrvalidin  input  1  execute returns a flag result this cycle
flagsin  input  4  returned flags; bit0 Z, bit1 C, bit2 N, bit3 V
flushin  input  1  pipeline flush (branch taken or exception)
issuevalidout  output  1  registered; an instruction issued last cycle
issueexecout  output  1  registered; 1 = execute, 0 = annul; meaningful only when issuevalidout=1
cpsrout  output  4  current architectural CPSR, same bit order as flagsin
pendout  output  CNTW  current in-flight flag-writer count
errout  output  1  registered one-cycle pulse on protocol error

Behaviour:
- Reset (reset_n=0 at a clock edge): cpsr=0000, pend=0, issuevalidout=0, issueexecout=0, errout=0. While reset_n=0, instreadyout=0 combinationally.
- Condition evaluation, with cond=condin[3:1] and sel=condin[0]:
  - 000: sel^Z
  - 001: sel^C
  - 010: sel^N
  - 011: sel^V
  - 100: sel^(C&~Z)
  - 101: sel^~(N^V)
  - 110: sel^(~Z&~(N^V))
  - 111: always true, for both sel values
- Effective flags: flagsin when flagwrvalidin=1 (bypass), otherwise cpsr.
- Dependency stall: asserted when cond!=111 AND pend!=0, unless pend==1 AND flagwrvalidin=1. In that exception the only pending writer retires this cycle, so the instruction evaluates against the bypassed flags.
- Capacity stall: asserted when setflagsin=1 AND pend==MAXPEND AND flagwrvalidin=0.
- instreadyout = reset_n & ~flushin & ~dependency stall & ~capacity stall. It is purely combinational from inputs and state. An instruction is accepted when instvalidin & instreadyout.
- Issue latency is 1 cycle:
  - issuevalidout <= accepted.
  - issueexecout <= cond result against the effective flags when accepted, else 0.
  - With no accept, issuevalidout=0 on the next cycle (no hold; decode re-presents while stalled).
- CPSR update: cpsr <= flagsin whenever flagwrvalidin=1, including during flush. The returning writer is older than the flush and commits.
- Pending counter:
  - inc = accepted & setflagsin & cond result true. Annulled instructions never write flags.
  - dec = flagwrvalidin & (pend!=0).
  - Next pend = pend + inc - dec; inc and dec in the same cycle leave pend unchanged.
- Flush: flushin=1 forces pend <= 0 and issuevalidout <= 0 next cycle, and blocks acceptance that cycle. Flush takes priority over inc.
- Error: flagwrvalidin=1 with pend==0 and no flush → errout <= 1 for one cycle. CPSR is still written and pend stays 0.
- Counter never wraps. Overflow is prevented by the capacity stall; underflow is prevented by the dec guard.
- Reset asserted mid-stall or with writers in flight returns all state to reset values. Late flag returns after reset raise errout.

Test Plan:
- Reset, then always-cond (condin=1110) with instvalidin=1 every cycle → instreadyout=1; next-cycle issuevalidout=1, issueexecout=1; pend=0, cpsrout=0000.
- Flags-set then dependency:
  - Accept ADDS (1110, setflagsin=1) → pend=1.
  - Present BEQ (0000) → instreadyout=0 while pend=1.
  - On the cycle flagwrvalidin=1 with flagsin=0001 → BEQ accepted that cycle; next cycle issueexecout=1, cpsrout=0001, pend=0.
- Annul: with cpsr=0001, issue NE (0001) with setflagsin=1 → issueexecout=0 and pend stays 0.
- Capacity: accept 3 always-cond flag setters → pend=3; 4th setter stalls. Same cycle flagwrvalidin=1 → 4th accepted, pend remains 3.
- Flush: with pend=2, flushin=1 plus flagwrvalidin=1 with flagsin=1010 → instreadyout=0; next cycle pend=0, cpsrout=1010, issuevalidout=0, errout=0.
- Error: pend=0, flagwrvalidin=1 with flagsin=0100 → errout pulses 1 for one cycle, cpsrout=0100, pend=0.
